// File: rtl/cv32e40p_popcnt_sched_pkg.sv
// Shared types for the popcount scheduler.
package cv32e40p_popcnt_sched_pkg;

  localparam int unsigned POPCNT_RES_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } popcnt_sched_state_e;

endpackage

// File: rtl/cv32e40p_rr_arbiter.sv
// Round-robin arbiter: scans from ptr_i+1 upward with wrap, grants first active request.
module cv32e40p_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  input  logic                     en_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  int unsigned      k;
  logic [IDX_W-1:0] kk;
  logic             found;

  // Priority scan starting just after the last granted requester
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    kk    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      k  = (32'(ptr_i) + i) % N_REQ;
      kk = IDX_W'(k);
      if (en_i && !found && req_i[kk]) begin
        gnt_o[kk] = 1'b1;
        idx_o     = kk;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_popcnt_ft_sched.sv
// Scheduler sharing one TMR popcount unit among N_REQ requesters.
// Optional error event counters enabled by CV32E40P_POPCNT_SCHED_ERRCNT_EN.
module cv32e40p_popcnt_ft_sched
  import cv32e40p_popcnt_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned LEN       = 32,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ-1:0][LEN-1:0]     req_data_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [$clog2(N_REQ)-1:0]      resp_id_o,
  output logic [POPCNT_RES_W-1:0]       resp_data_o,
  output logic                          resp_err_o,
  output logic [LEN-1:0]                pc_in_o,
  input  logic [POPCNT_RES_W-1:0]       pc_result_i,
  input  logic                          pc_error_correct_i,
  input  logic                          pc_error_detected_i,
  output logic [CNT_W-1:0]              corr_cnt_o,
  output logic [CNT_W-1:0]              uncorr_cnt_o
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  popcnt_sched_state_e state_q, state_d;

  logic [LEN-1:0]          op_q, op_d;
  logic [IDX_W-1:0]        id_q, id_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [POPCNT_RES_W-1:0] resp_data_q, resp_data_d;
  logic [IDX_W-1:0]        resp_id_q, resp_id_d;
  logic                    resp_err_q, resp_err_d;

  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             hs;
  logic             ue;
  logic             retry_ok;

  cv32e40p_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign hs       = |(req_valid_i & gnt);
  assign ue       = pc_error_detected_i & ~pc_error_correct_i;
  assign retry_ok = (retry_q < RETRY_W'(MAX_RETRY));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    if (!(ue && retry_ok)) state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE (arbiter enable), response valid in RESP
  always_comb begin
    req_ready_o  = gnt;
    resp_valid_o = (state_q == RESP);
  end

  // Datapath next values: capture on handshake, retry or register result in EXEC
  always_comb begin
    op_d        = op_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    retry_d     = retry_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = req_data_i[gnt_idx];
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          retry_d = '0;
        end
      end
      EXEC: begin
        if (ue && retry_ok) begin
          retry_d = retry_q + RETRY_W'(1);
        end else begin
          resp_data_d = pc_result_i;
          resp_id_d   = id_q;
          resp_err_d  = ue;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      id_q        <= '0;
      ptr_q       <= IDX_W'(N_REQ - 1);
      retry_q     <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      op_q        <= op_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      retry_q     <= retry_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // op_q only changes on a handshake, so the unit operand stays quiet in IDLE
  assign pc_in_o     = op_q;
  assign resp_data_o = resp_data_q;
  assign resp_id_o   = resp_id_q;
  assign resp_err_o  = resp_err_q;

`ifdef CV32E40P_POPCNT_SCHED_ERRCNT_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  // Saturating error event counters, counted per EXEC cycle
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (state_q == EXEC) begin
      if (pc_error_correct_i && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (ue && (uncorr_cnt_q != '1))               uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
`else
  assign corr_cnt_o   = '0;
  assign uncorr_cnt_o = '0;
`endif

endmodule
